// File: rtl/branch_resolve_unit.sv
// Resolves a conditional branch and drives the PC load and fetch flush. Handshake: req_ready is high only in IDLE, one request in flight.
// Latency from the accept edge to resolved_valid: 2 cycles if not taken, 2+FLUSH_CYCLES if taken. Outputs are registered one cycle behind the state.
module branch_resolve_unit #(
  parameter int DATA_W       = 16,
  parameter int OFF_W        = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic [DATA_W-1:0] pc,
  input  logic [OFF_W-1:0]  offset,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_target,
  output logic              flush,
  output logic              resolved_valid,
  output logic              resolved_taken,
  output logic [15:0]       taken_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

  state_t state_q, state_d;

  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] rs_q, rs_d;
  logic [DATA_W-1:0] rt_q, rt_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              taken_q, taken_d;

  logic              req_ready_q, req_ready_d;
  logic              pc_load_q, pc_load_d;
  logic [DATA_W-1:0] pc_target_q, pc_target_d;
  logic              flush_q, flush_d;
  logic              resolved_valid_q, resolved_valid_d;
  logic              resolved_taken_q, resolved_taken_d;
  logic [15:0]       taken_count_q, taken_count_d;

  logic              accept;
  logic              cond;
  logic [DATA_W-1:0] off_ext;
  logic [DATA_W-1:0] target;

  assign accept  = (state_q == IDLE) && req_valid && req_ready_q;
  assign off_ext = {{(DATA_W-OFF_W){off_q[OFF_W-1]}}, off_q};
  // Offset is in words relative to the instruction after the branch; wraps silently.
  assign target  = pc_q + DATA_W'(1) + off_ext;

  always_comb begin
    cond = 1'b0;
    case (op_q)
      2'b00:   cond = (rs_q == rt_q);
      2'b01:   cond = (rs_q != rt_q);
      2'b10:   cond = (rs_q != '0);
      default: cond = (rs_q == '0);
    endcase
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      op_q             <= '0;
      rs_q             <= '0;
      rt_q             <= '0;
      pc_q             <= '0;
      off_q            <= '0;
      cnt_q            <= '0;
      taken_q          <= 1'b0;
      req_ready_q      <= 1'b1;
      pc_load_q        <= 1'b0;
      pc_target_q      <= '0;
      flush_q          <= 1'b0;
      resolved_valid_q <= 1'b0;
      resolved_taken_q <= 1'b0;
      taken_count_q    <= '0;
    end else begin
      state_q          <= state_d;
      op_q             <= op_d;
      rs_q             <= rs_d;
      rt_q             <= rt_d;
      pc_q             <= pc_d;
      off_q            <= off_d;
      cnt_q            <= cnt_d;
      taken_q          <= taken_d;
      req_ready_q      <= req_ready_d;
      pc_load_q        <= pc_load_d;
      pc_target_q      <= pc_target_d;
      flush_q          <= flush_d;
      resolved_valid_q <= resolved_valid_d;
      resolved_taken_q <= resolved_taken_d;
      taken_count_q    <= taken_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    pc_d    = pc_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    taken_d = taken_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = op;
          rs_d    = rs_val;
          rt_d    = rt_val;
          pc_d    = pc;
          off_d   = offset;
          state_d = EVAL;
        end
      end
      EVAL: begin
        taken_d = cond;
        cnt_d   = FLUSH_LOAD;
        state_d = cond ? FLUSH : DONE;
      end
      FLUSH: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Ready tracks the next state so it drops on the accept edge itself.
  always_comb begin
    req_ready_d      = (state_d == IDLE);
    pc_load_d        = (state_q == FLUSH) && (cnt_q == FLUSH_LOAD);
    flush_d          = (state_q == FLUSH);
    resolved_valid_d = (state_q == DONE);
    resolved_taken_d = (state_q == DONE) && taken_q;
    pc_target_d      = (state_q == EVAL) ? target : pc_target_q;
    taken_count_d    = taken_count_q;
    if (pc_load_d && (taken_count_q != 16'hFFFF)) begin
      taken_count_d = taken_count_q + 16'd1;
    end
  end

  assign req_ready      = req_ready_q;
  assign pc_load        = pc_load_q;
  assign pc_target      = pc_target_q;
  assign flush          = flush_q;
  assign resolved_valid = resolved_valid_q;
  assign resolved_taken = resolved_taken_q;
  assign taken_count    = taken_count_q;

  a_load_in_flush: assert property (@(posedge clk) disable iff (!rst_n) pc_load_q |-> flush_q);
  a_done_no_flush: assert property (@(posedge clk) disable iff (!rst_n) resolved_valid_q |-> !flush_q);
  a_taken_qual:    assert property (@(posedge clk) disable iff (!rst_n) resolved_taken_q |-> resolved_valid_q);

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: vector table plus reset, back-to-back and saturation sequences.
module tb_branch_resolve_unit;

  localparam int FC = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  op;
  logic [15:0] rs_val;
  logic [15:0] rt_val;
  logic [15:0] pc;
  logic [7:0]  offset;
  logic        pc_load;
  logic [15:0] pc_target;
  logic        flush;
  logic        resolved_valid;
  logic        resolved_taken;
  logic [15:0] taken_count;

  branch_resolve_unit #(
    .DATA_W(16),
    .OFF_W(8),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .op(op),
    .rs_val(rs_val),
    .rt_val(rt_val),
    .pc(pc),
    .offset(offset),
    .pc_load(pc_load),
    .pc_target(pc_target),
    .flush(flush),
    .resolved_valid(resolved_valid),
    .resolved_taken(resolved_taken),
    .taken_count(taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] rs;
    logic [15:0] rt;
    logic [15:0] pc;
    logic [7:0]  off;
    logic        taken;
    logic [15:0] target;
  } vec_t;

  typedef struct {
    logic        taken;
    logic [15:0] target;
    logic [15:0] cnt;
    int          acc;
  } exp_t;

  vec_t        vecs [10];
  exp_t        sbq [$];
  int          checks;
  int          fails;
  int          cyc;
  int          fl_cnt;
  int          pl_cnt;
  int          n_resolved;
  logic [15:0] cnt_model;
  logic        cur_taken;
  logic [15:0] cur_target;
  bit          sb_en;
  bit          accepted;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Advance to the next falling edge, scoring accepts and DUT outputs seen there.
  task automatic tick();
    bit   acc_now;
    exp_t e;
    acc_now = req_valid && req_ready && rst_n;
    @(negedge clk);
    cyc++;
    if (acc_now) begin
      accepted = 1'b1;
      if (sb_en) begin
        if (cur_taken && cnt_model != 16'hFFFF) cnt_model++;
        e.taken  = cur_taken;
        e.target = cur_target;
        e.cnt    = cnt_model;
        e.acc    = cyc;
        sbq.push_back(e);
      end
    end
    if (flush) fl_cnt++;
    if (pc_load) begin
      pl_cnt++;
      if (sbq.size() > 0) chk("pc_target_at_load", 32'(pc_target), 32'(sbq[0].target));
    end
    if (resolved_valid) begin
      n_resolved++;
      if (sbq.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_resolve got=resolved_valid exp=no_request_outstanding");
      end else begin
        e = sbq.pop_front();
        chk("resolved_taken", 32'(resolved_taken), 32'(e.taken));
        chk("latency", 32'(cyc - e.acc), e.taken ? 32'(2 + FC) : 32'd2);
        chk("flush_cycles", 32'(fl_cnt), e.taken ? 32'(FC) : 32'd0);
        chk("pc_load_pulses", 32'(pl_cnt), e.taken ? 32'd1 : 32'd0);
        chk("pc_target", 32'(pc_target), 32'(e.target));
        chk("taken_count", 32'(taken_count), 32'(e.cnt));
      end
      fl_cnt = 0;
      pl_cnt = 0;
    end
  endtask

  task automatic send(input vec_t v, input bit hold);
    int t;
    req_valid  = 1'b1;
    op         = v.op;
    rs_val     = v.rs;
    rt_val     = v.rt;
    pc         = v.pc;
    offset     = v.off;
    cur_taken  = v.taken;
    cur_target = v.target;
    accepted   = 1'b0;
    t = 0;
    while (!accepted && t < 40) begin
      tick();
      t++;
    end
    if (!accepted) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout got=req_ready_low exp=accept_within_40");
    end
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() > 0 && t < 60) begin
      tick();
      t++;
    end
    chk("drain_outstanding", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    int t;
    int base;
    // op, rs, rt, pc, offset, expected taken, expected target
    vecs[0] = '{2'b10, 16'h0001, 16'h0000, 16'h0010, 8'h05, 1'b1, 16'h0016};
    vecs[1] = '{2'b00, 16'h1234, 16'h1235, 16'h0200, 8'h10, 1'b0, 16'h0211};
    vecs[2] = '{2'b01, 16'h0005, 16'h0006, 16'hFFFE, 8'h03, 1'b1, 16'h0002};
    vecs[3] = '{2'b01, 16'h0007, 16'h0007, 16'h0100, 8'h80, 1'b0, 16'h0081};
    vecs[4] = '{2'b00, 16'hABCD, 16'hABCD, 16'h0000, 8'hFF, 1'b1, 16'h0000};
    vecs[5] = '{2'b11, 16'h0000, 16'h5555, 16'h1000, 8'h7F, 1'b1, 16'h1080};
    vecs[6] = '{2'b11, 16'h8000, 16'h0000, 16'h0000, 8'h80, 1'b0, 16'hFF81};
    vecs[7] = '{2'b10, 16'h0000, 16'hFFFF, 16'h2000, 8'h00, 1'b0, 16'h2001};
    vecs[8] = '{2'b01, 16'h8000, 16'h0000, 16'h7FFF, 8'h01, 1'b1, 16'h8001};
    vecs[9] = '{2'b00, 16'hFFFF, 16'h7FFF, 16'hFFFF, 8'h00, 1'b0, 16'h0000};

    checks = 0; fails = 0; cyc = 0; fl_cnt = 0; pl_cnt = 0; n_resolved = 0;
    cnt_model = 16'h0000; cur_taken = 1'b0; cur_target = 16'h0000;
    sb_en = 1'b1; accepted = 1'b0;
    rst_n = 1'b0; req_valid = 1'b0; op = 2'b00;
    rs_val = '0; rt_val = '0; pc = '0; offset = '0;

    #3;
    chk("rst_pc_load", 32'(pc_load), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_resolved_valid", 32'(resolved_valid), 32'd0);
    chk("rst_resolved_taken", 32'(resolved_taken), 32'd0);
    chk("rst_taken_count", 32'(taken_count), 32'd0);
    chk("rst_pc_target", 32'(pc_target), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_release", 32'(req_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      send(vecs[i], 1'b0);
      drain();
    end

    // req_valid never drops across three requests.
    base = n_resolved;
    send(vecs[5], 1'b1);
    send(vecs[1], 1'b1);
    send(vecs[0], 1'b1);
    req_valid = 1'b0;
    drain();
    repeat (4) tick();
    chk("held_resolve_count", 32'(n_resolved - base), 32'd3);

    // Reset in the first flush cycle of a taken BEQZ.
    sb_en = 1'b0;
    req_valid = 1'b1; op = 2'b11; rs_val = 16'h0000; rt_val = 16'h1111;
    pc = 16'h0040; offset = 8'h04;
    accepted = 1'b0;
    tick();
    req_valid = 1'b0;
    chk("rst_test_accept", 32'(accepted), 32'd1);
    t = 0;
    while (!pc_load && t < 10) begin
      tick();
      t++;
    end
    chk("rst_test_reach_flush", 32'(pc_load), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_flush", 32'(flush), 32'd0);
    chk("midrst_pc_load", 32'(pc_load), 32'd0);
    chk("midrst_taken_count", 32'(taken_count), 32'd0);
    chk("midrst_resolved_valid", 32'(resolved_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_ready_after_release", 32'(req_ready), 32'd1);
    fl_cnt = 0; pl_cnt = 0; cnt_model = 16'h0000; sb_en = 1'b1;
    base = n_resolved;
    repeat (8) tick();
    chk("midrst_no_resolve", 32'(n_resolved - base), 32'd0);
    chk("midrst_no_flush", 32'(fl_cnt), 32'd0);

    // Counter saturation.
    force dut.taken_count_q = 16'hFFFE;
    tick();
    release dut.taken_count_q;
    cnt_model = 16'hFFFE;
    tick();
    chk("sat_preload", 32'(taken_count), 32'h0000FFFE);
    send(vecs[0], 1'b0);
    drain();
    send(vecs[2], 1'b0);
    drain();
    chk("sat_hold", 32'(taken_count), 32'h0000FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Sequential branch-resolution block for the 16-bit CPU datapath.
- Consumes the 0/1 set-less-than result the ALU writes to a register, and also compares two register operands.
- Decides whether a conditional branch is taken, computes the target PC, issues a one-cycle PC load and holds a pipeline flush.
- Sits between decode/register-read and the PC/fetch stage; talks to decode through a valid/ready handshake.

Parameters:
- DATA_W, 16, operand and PC width in bits.
- OFF_W, 8, width of the signed branch offset in words.
- FLUSH_CYCLES, 2, cycles `flush` stays high after a taken branch. Legal range is 1 to 15.

Ports:
- clk  in  1  system clock; rising-edge active.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  decode presents a branch request.
- req_ready  out  1  unit can accept a request.
- op  in  2  condition: 00 BEQ (rs==rt), 01 BNE (rs!=rt), 10 BNEZ (rs!=0, the slt-consumer form), 11 BEQZ (rs==0).
- rs_val  in  DATA_W  first operand.
- rt_val  in  DATA_W  second operand; ignored for ops 10 and 11.
- pc  in  DATA_W  PC of the branch instruction.
- offset  in  OFF_W  signed word offset.
- pc_load  out  1  one-cycle strobe to load pc_target into the PC.
- pc_target  out  DATA_W  branch target address.
- flush  out  1  squash younger instructions in fetch/decode.
- resolved_valid  out  1  one-cycle completion pulse.
- resolved_taken  out  1  outcome; valid only while resolved_valid is high.
- taken_count  out  16  saturating count of taken branches.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs go to 0, including taken_count and pc_target.
  - Latched operands are cleared.
  - Exception: req_ready reads 1 once rst_n is released.
- States: IDLE, EVAL, FLUSH, DONE. State and all outputs are registered.
- IDLE:
  - req_ready=1.
  - On clock edge with req_valid&&req_ready: latch op, rs_val, rt_val, pc, offset; go to EVAL.
  - Inputs are ignored in every other state (req_ready=0).
- EVAL (1 cycle):
  - cond is evaluated per op on the latched values.
  - Target = latched pc + 1 + sign-extended offset, modulo 2^DATA_W. Wrap-around at 0xFFFF/0x0000 is silent.
  - pc_target is registered on exit from EVAL and holds until the next EVAL.
  - If cond is true: go to FLUSH. In the first FLUSH cycle pc_load=1 and flush=1, with a counter loaded to FLUSH_CYCLES.
  - If cond is false: go to DONE. No pc_load, no flush.
- FLUSH:
  - flush=1 for exactly FLUSH_CYCLES consecutive cycles.
  - pc_load=1 only in the first of those cycles.
  - taken_count increments once, saturating at 0xFFFF.
  - After the last flush cycle, go to DONE.
- DONE (1 cycle):
  - resolved_valid=1 and resolved_taken=cond; then go to IDLE.
  - flush=0 and pc_load=0.
- Latency, accept edge to resolved_valid high:
  - not taken: 2 cycles.
  - taken: 2+FLUSH_CYCLES cycles.
- Issue rate: at most one request outstanding. The next request is accepted in the cycle after DONE, since req_ready rises with IDLE.
- Operand comparisons are unsigned bitwise equality; no signed interpretation except for offset.
- Reset mid-operation (any state): abort immediately, outputs to 0, no pc_load or resolved pulse afterwards. taken_count is cleared.
- If req_valid is held high continuously, back-to-back requests are each accepted once per IDLE visit; none is lost or duplicated.

Test Plan:
- Reset release, then BNEZ with rs=0x0001 (slt true), pc=0x0010, offset=0x05:
  - pc_load pulse with pc_target=0x0016;
  - flush high 2 cycles;
  - resolved_valid/taken=1 at accept+4;
  - taken_count=1.
- BEQ with rs=0x1234, rt=0x1235:
  - resolved_taken=0 at accept+2;
  - pc_load and flush never high;
  - taken_count unchanged.
- BNE with pc=0xFFFE, offset=0x03: pc_target=0x0002 (wrap); offset=0x80 with pc=0x0100 gives 0x0081.
- Reset asserted during FLUSH cycle 1 of a taken BEQZ (rs=0):
  - flush, pc_load and taken_count drop to 0 asynchronously;
  - no resolved_valid after release;
  - req_ready=1 on the first cycle after release.
- req_valid held high for 3 alternating taken/not-taken requests: exactly 3 resolved_valid pulses in order, none accepted while busy.
- Preload taken_count to 0xFFFF via 65535 taken branches (or force), one more taken branch: taken_count stays 0xFFFF.
